// File: rtl/count_pkg.sv
// Shared definitions for blocks that live in the free-running counter domain.
// Holds the sequence-monitor FSM encoding and the default counter width.
package count_pkg;

    localparam int CNT_W_DEFAULT = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACQ  = 2'd1,
        ST_LOCK = 2'd2
    } cnt_state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear together with an
// increment restarts the count at one instead of zero.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    localparam logic [W-1:0] CNT_MAX = '1;

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // NOTE: cnt_d gets its default first so no path through the block leaves it unassigned (no latch).
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = inc ? W'(1) : '0;
        end else if (inc && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/count_seq_monitor.sv
// Checks that a free-running counter advances by exactly +1 (mod 2^CNT_W) each clock,
// declares lock after LOCK_LEN good steps, and counts verified wraps and lock breaks.
module count_seq_monitor
    import count_pkg::*;
#(
    parameter int CNT_W    = CNT_W_DEFAULT,
    parameter int LOCK_LEN = 4,
    parameter int WRAP_W   = 16,
    parameter int ERR_W    = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [CNT_W-1:0]  count_in,
    input  logic              clr_err,
    output logic              locked,
    output logic              wrap_pulse,
    output logic [WRAP_W-1:0] wrap_cnt,
    output logic              err_flag,
    output logic [ERR_W-1:0]  err_cnt,
    output logic [CNT_W-1:0]  last_count
);

    localparam int RUN_W = (LOCK_LEN < 1) ? 1 : $clog2(LOCK_LEN + 1);

    cnt_state_e        state_q,      state_d;
    logic [RUN_W-1:0]  good_run_q,   good_run_d;
    logic              locked_q,     locked_d;
    logic              wrap_pulse_q, wrap_pulse_d;
    logic [WRAP_W-1:0] wrap_cnt_q,   wrap_cnt_d;
    logic              err_flag_q,   err_flag_d;
    logic [CNT_W-1:0]  last_count_q;

    logic [CNT_W-1:0]  expected;
    logic [RUN_W-1:0]  next_run;
    logic              good_step;
    logic              lock_break;

    assign expected  = last_count_q + CNT_W'(1);
    assign good_step = (count_in == expected);
    assign next_run  = good_run_q + RUN_W'(1);

    always_comb begin
        state_d      = state_q;
        good_run_d   = good_run_q;
        locked_d     = locked_q;
        wrap_pulse_d = 1'b0;
        wrap_cnt_d   = wrap_cnt_q;
        err_flag_d   = err_flag_q;
        lock_break   = 1'b0;

        // A lock break later in this block overrides the clear.
        if (clr_err) begin
            err_flag_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                state_d    = ST_ACQ;
                good_run_d = '0;
                locked_d   = 1'b0;
            end

            ST_ACQ: begin
                if (good_step) begin
                    if (next_run == RUN_W'(LOCK_LEN)) begin
                        state_d    = ST_LOCK;
                        locked_d   = 1'b1;
                        good_run_d = '0;
                    end else begin
                        good_run_d = next_run;
                    end
                end else begin
                    good_run_d = '0;
                end
            end

            ST_LOCK: begin
                if (good_step) begin
                    if (count_in == '0) begin
                        wrap_pulse_d = 1'b1;
                        wrap_cnt_d   = wrap_cnt_q + WRAP_W'(1);
                    end
                end else begin
                    state_d    = ST_ACQ;
                    locked_d   = 1'b0;
                    good_run_d = '0;
                    err_flag_d = 1'b1;
                    lock_break = 1'b1;
                end
            end

            default: begin
                state_d    = ST_IDLE;
                good_run_d = '0;
                locked_d   = 1'b0;
            end
        endcase
    end

    // NOTE: reset clears every status register, including last_count, so all outputs read 0 after it.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            good_run_q   <= '0;
            locked_q     <= 1'b0;
            wrap_pulse_q <= 1'b0;
            wrap_cnt_q   <= '0;
            err_flag_q   <= 1'b0;
            last_count_q <= '0;
        end else begin
            state_q      <= state_d;
            good_run_q   <= good_run_d;
            locked_q     <= locked_d;
            wrap_pulse_q <= wrap_pulse_d;
            wrap_cnt_q   <= wrap_cnt_d;
            err_flag_q   <= err_flag_d;
            last_count_q <= count_in;
        end
    end

    sat_counter #(
        .W (ERR_W)
    ) u_err_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (clr_err),
        .inc   (lock_break),
        .cnt   (err_cnt)
    );

    assign locked     = locked_q;
    assign wrap_pulse = wrap_pulse_q;
    assign wrap_cnt   = wrap_cnt_q;
    assign err_flag   = err_flag_q;
    assign last_count = last_count_q;

endmodule
